// File: rtl/seq_divider_32.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (default build is unsigned).
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
    logic             r_dbz;

    logic             w_accept;
    logic             w_zero;
    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_d;
    logic [WIDTH-1:0] w_nrem;
    logic [WIDTH-1:0] w_nquo;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_res;
    logic [WIDTH-1:0] w_r_res;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign quotient    = r_q_out;
    assign remainder   = r_r_out;
    assign div_by_zero = r_dbz;

    assign w_accept = in_valid && in_ready;
    assign w_zero   = (divisor == '0);

    // T never exceeds 2^WIDTH-1 when a borrow occurs, so truncating T is safe
    assign w_t    = {r_rem, r_quo[WIDTH-1]};
    assign w_d    = w_t - {1'b0, r_dvsr};
    assign w_nrem = w_d[WIDTH] ? w_t[WIDTH-1:0] : w_d[WIDTH-1:0];
    assign w_nquo = {r_quo[WIDTH-2:0], ~w_d[WIDTH]};

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_b_mag = divisor[WIDTH-1] ? -divisor : divisor;
    assign w_q_res = r_neg_q ? -w_nquo : w_nquo;
    assign w_r_res = r_neg_r ? -w_nrem : w_nrem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign w_a_mag = dividend;
    assign w_b_mag = divisor;
    assign w_q_res = w_nquo;
    assign w_r_res = w_nrem;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = w_zero ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == '0) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_cnt   <= '0;
            r_q_out <= '0;
            r_r_out <= '0;
            r_dbz   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dbz <= w_zero;
                if (w_zero) begin
                    r_q_out <= '1;
                    r_r_out <= dividend;
                end else begin
                    r_rem  <= '0;
                    r_quo  <= w_a_mag;
                    r_dvsr <= w_b_mag;
                    r_cnt  <= CW'(WIDTH - 1);
                end
            end
            if (r_state == S_CALC) begin
                r_rem <= w_nrem;
                r_quo <= w_nquo;
                r_cnt <= r_cnt - 1'b1;
                // publish on the last step so results appear with DONE
                if (r_cnt == '0) begin
                    r_q_out <= w_q_res;
                    r_r_out <= w_r_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_32.sv
// Randomised self-checking bench for seq_divider_32 against an arithmetic model.
// Handles both the unsigned and DIV_SIGNED_EN builds.
module tb_seq_divider_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic d);
        longint sa, sb, sq, sr;
        if (b == 0) begin
            q = '1;
            r = a;
            d = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa - sq * sb;
            q  = sq[31:0];
            r  = sr[31:0];
`else
            sa = 0; sb = 0; sq = 0; sr = 0;
            q = a / b;
            r = a % b;
`endif
            d = 1'b0;
        end
    endfunction

    // lat = edges after the accepting edge until out_valid is seen (bounded)
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 64'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: rdy=%b ov=%b q=%h r=%h dbz=%b, want 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_basic();
        int lat;
        do_op(32'd100, 32'd7, lat);
        n_cmp++;
        if (lat !== 32) begin n_err++; $display("FAIL basic_lat: got %0d want 32", lat); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
            n_err++;
            $display("FAIL basic_res: q=%0d r=%0d dbz=%b want 14 2 0", quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL basic_ready: rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_edges();
        int lat;
        do_op(32'hFFFF_FFFF, 32'd1, lat);
        n_cmp++;
        if ({quotient, remainder} !== {32'hFFFF_FFFF, 32'd0}) begin
            n_err++;
            $display("FAIL max_by_one: q=%h r=%h want ffffffff 0", quotient, remainder);
        end
        @(posedge clk);
        #1;
        do_op(32'h1234_5678, 32'h1234_5679, lat);
        n_cmp++;
        if ({quotient, remainder} !== {32'd0, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL small_num: q=%h r=%h want 0 12345678", quotient, remainder);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(32'd5, 32'd0, lat);
        n_cmp++;
        if (lat !== 0) begin n_err++; $display("FAIL dbz_lat: got %0d want 0", lat); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, 32'd5, 1'b1}) begin
            n_err++;
            $display("FAIL dbz_res: q=%h r=%h dbz=%b want ffffffff 5 1", quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_hold: got %b want 1", div_by_zero); end
        do_op(32'd20, 32'd6, lat);
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {32'd3, 32'd2, 1'b0}) begin
            n_err++;
            $display("FAIL dbz_clear: q=%0d r=%0d dbz=%b want 3 2 0", quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        do_op(32'd1000, 32'd10, lat);
        n_cmp++;
        if (lat !== 32) begin n_err++; $display("FAIL bp_lat: got %0d want 32", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n_cmp++;
            if ({out_valid, in_ready, quotient, remainder} !== {2'b10, 32'd100, 32'd0}) begin
                n_err++;
                $display("FAIL bp_hold%0d: ov=%b rdy=%b q=%0d r=%0d want 1 0 100 0",
                         i, out_valid, in_ready, quotient, remainder);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready, quotient} !== {2'b01, 32'd100}) begin
            n_err++;
            $display("FAIL bp_release: ov=%b rdy=%b q=%0d want 0 1 100", out_valid, in_ready, quotient);
        end
    endtask

    task automatic test_reset_midcalc();
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'd123456;
        divisor  = 32'd789;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 64'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: rdy=%b ov=%b q=%h r=%h dbz=%b want 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        do_op(32'd9, 32'd3, lat);
        n_cmp++;
        if ({quotient, remainder, lat} !== {32'd3, 32'd0, 32'd32}) begin
            n_err++;
            $display("FAIL after_reset: q=%0d r=%0d lat=%0d want 3 0 32", quotient, remainder, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sign_mode();
        int lat;
        logic [31:0] eq, er;
`ifdef DIV_SIGNED_EN
        eq = 32'hFFFF_FFFD;
        er = 32'hFFFF_FFFF;
`else
        eq = 32'h7FFF_FFFC;
        er = 32'd1;
`endif
        do_op(32'hFFFF_FFF9, 32'd2, lat);
        n_cmp++;
        if ({quotient, remainder} !== {eq, er}) begin
            n_err++;
            $display("FAIL sign_mode: q=%h r=%h want %h %h", quotient, remainder, eq, er);
        end
        @(posedge clk);
        #1;
`ifdef DIV_SIGNED_EN
        do_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {32'h8000_0000, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL overflow: q=%h r=%h dbz=%b want 80000000 0 0", quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_random();
        int lat, sel, hold;
        logic [31:0] a, b, eq, er;
        logic ed;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel < 4) b = $urandom_range(1, 15);
            else if (sel == 4) b = 32'hFFFF_FFFF;
            else if (sel == 5) b = a + 32'd1;
            else b = $urandom >> $urandom_range(0, 28);
            if (b == 0 && sel != 0) b = 32'd1;
            ref_div(a, b, eq, er, ed);
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            do_op(a, b, lat);
            n_cmp++;
            if ({quotient, remainder, div_by_zero} !== {eq, er, ed} || lat !== (ed ? 0 : 32)) begin
                n_err++;
                $display("FAIL rand%0d: %h/%h q=%h r=%h dbz=%b lat=%0d want %h %h %b %0d",
                         i, a, b, quotient, remainder, div_by_zero, lat, eq, er, ed, ed ? 0 : 32);
            end
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            n_cmp++;
            if ({in_ready, out_valid, quotient} !== {2'b10, eq}) begin
                n_err++;
                $display("FAIL rand_ret%0d: rdy=%b ov=%b q=%h want 1 0 %h", i, in_ready, out_valid, quotient, eq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_backpressure();
        test_reset_midcalc();
        test_sign_mode();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
